mux_n1_stream: RTL

//  Parametrised N:1 registered stream multiplexer with valid/ready handshaking on every port.

---
 rtl/mm_pkg.sv | 13 +
 rtl/mux_n1_stream_if.sv | 31 +++
 rtl/mux_n1_stream_rr_arbiter.sv | 44 ++++
 rtl/mux_n1_stream.sv | 72 +++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the N-way stream blocks: mode encodings and the
// channel-index width helper.
package mm_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an N-way selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n1_stream_if.sv
// Handshake bundle for the N:1 stream mux: control, N input channels and the
// single output channel.
interface mux_n1_stream_if
  import mm_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = idx_w(NUM_IN)
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side (drives inputs, takes outputs).
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Mux side.
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_n1_stream_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at the pointer and wraps; the
// pointer moves one past the winner whenever the grant is accepted.
module rr_arbiter
  import mm_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SEL_W = idx_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req_i,
  input  logic              accept_i,
  output logic [NUM_IN-1:0] gnt_oh_o,
  output logic [SEL_W-1:0]  gnt_idx_o,
  output logic              any_gnt_o
);

  logic [SEL_W-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer, modulo NUM_IN.
  always_comb begin
    int c;
    c         = 0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (!any_gnt_o && req_i[SEL_W'(c)]) begin
        any_gnt_o = 1'b1;
        gnt_idx_o = SEL_W'(c);
      end
    end
    gnt_oh_o = any_gnt_o ? (NUM_IN'(1) << gnt_idx_o) : '0;
    ptr_d    = (int'(gnt_idx_o) == NUM_IN - 1) ? '0 : gnt_idx_o + 1'b1;
  end

  // Pointer advances only on an accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ptr_q <= '0;
    else if (accept_i && any_gnt_o)  ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_n1_stream.sv
// Registered N:1 stream mux. Grant comes from sel (fixed mode) or the
// round-robin arbiter; a single output register gives 1-cycle latency and
// full throughput, stalling all inputs while the held word is not drained.
module mux_n1_stream
  import mm_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = idx_w(NUM_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_n1_stream_if.slave   bus
);

  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_ch_q;
  logic              out_valid_q;

  logic              load_en;
  logic              fx_gnt, gnt_any, xfer;
  logic [SEL_W-1:0]  gnt_idx;
  logic [NUM_IN-1:0] rr_oh, rdy;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  assign load_en = !out_valid_q || bus.out_ready;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.in_valid),
    .accept_i  (xfer && (bus.mode == MODE_RR)),
    .gnt_oh_o  (rr_oh),
    .gnt_idx_o (rr_idx),
    .any_gnt_o (rr_any)
  );

  // Grant selection; an out-of-range sel never grants. in_ready is gated by
  // rst_n so nothing is acknowledged while the block is held in reset.
  always_comb begin
    fx_gnt = 1'b0;
    if (int'(bus.sel) < NUM_IN) fx_gnt = bus.in_valid[bus.sel];
    gnt_any = (bus.mode == MODE_RR) ? rr_any : fx_gnt;
    gnt_idx = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
    xfer    = gnt_any && load_en && rst_n;
    for (int i = 0; i < NUM_IN; i++)
      rdy[i] = xfer && (int'(gnt_idx) == i);
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

  // Output register: load on transfer (replacing a draining word), clear
  // valid on a drain with nothing new, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_data_q  <= bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_ch_q    <= gnt_idx;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
